// File: rtl/moldudp64_pkg.sv
// Shared types and default widths for the MoldUDP64 miss re-request path.
package moldudp64_pkg;

    localparam int unsigned DEF_SEQ_NUM_W = 64;
    localparam int unsigned DEF_SID_W     = 80;
    localparam int unsigned DEF_ML_W      = 16;

    // One missed sequence-number range as queued between detector and requester.
    typedef struct packed {
        logic [DEF_SID_W-1:0]     sid;
        logic [DEF_SEQ_NUM_W-1:0] start;
        logic [DEF_SEQ_NUM_W-1:0] cnt;
    } miss_range_t;

    typedef enum logic {
        StIdle,
        StSend
    } req_state_t;

    // Unsigned add that keeps the carry out in the extra MSB.
    function automatic logic [DEF_SEQ_NUM_W:0] add_carry(
        input logic [DEF_SEQ_NUM_W-1:0] a,
        input logic [DEF_SEQ_NUM_W-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/miss_req_gen_fifo.sv
// miss_req_fifo: synchronous FIFO of miss ranges with full/empty flags and
// read/modify access to the newest (tail) entry, used when merging ranges.
module miss_req_fifo
    import moldudp64_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     push,
    input  miss_range_t              push_data,
    input  logic                     pop,
    output miss_range_t              head,
    output logic                     full,
    output logic                     empty,
    output logic                     last_entry,
    output miss_range_t              tail,
    input  logic                     tail_upd,
    input  logic [DEF_SEQ_NUM_W-1:0] tail_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]   wr_q, rd_q;
    logic [AW-1:0] wr_idx, rd_idx, tail_idx;
    logic          do_push, do_pop;
    miss_range_t   mem_q [DEPTH];

    assign wr_idx     = wr_q[AW-1:0];
    assign rd_idx     = rd_q[AW-1:0];
    assign tail_idx   = wr_idx - AW'(1);
    assign empty      = (wr_q == rd_q);
    assign full       = (wr_q[AW] != rd_q[AW]) && (wr_idx == rd_idx);
    assign last_entry = ((wr_q - rd_q) == (AW + 1)'(1));
    assign head       = mem_q[rd_idx];
    assign tail       = mem_q[tail_idx];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Read/write pointers.
    always_ff @(posedge clk) begin
        if (nreset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW + 1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW + 1)'(1);
        end
    end

    // Storage; push and tail update are never requested together.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= push_data;
        end else if (tail_upd) begin
            mem_q[tail_idx].cnt <= tail_cnt;
        end
    end

endmodule

// File: rtl/miss_req_gen.sv
// miss_req_gen: queues missed sequence ranges and emits MoldUDP64 re-request
// tuples {session, seq_num, msg_cnt}, splitting ranges wider than MAX_REQ_CNT.
// Optional: define MISS_REQ_MERGE_EN to merge a push contiguous with the tail entry.
module miss_req_gen
    import moldudp64_pkg::*;
#(
    parameter int unsigned SEQ_NUM_W   = DEF_SEQ_NUM_W,
    parameter int unsigned SID_W       = DEF_SID_W,
    parameter int unsigned ML_W        = DEF_ML_W,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned MAX_REQ_CNT = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 miss_v_i,
    input  logic [SID_W-1:0]     miss_sid_i,
    input  logic [SEQ_NUM_W-1:0] miss_start_i,
    input  logic [SEQ_NUM_W-1:0] miss_cnt_i,
    output logic                 req_v_o,
    input  logic                 req_ready_i,
    output logic [SID_W-1:0]     req_sid_o,
    output logic [SEQ_NUM_W-1:0] req_seq_num_o,
    output logic [ML_W-1:0]      req_msg_cnt_o,
    output logic                 busy_o,
    output logic                 ovf_o
);

    localparam logic [SEQ_NUM_W-1:0] MAX_EXT = SEQ_NUM_W'(MAX_REQ_CNT);

    req_state_t           state_q, state_d;
    logic [SID_W-1:0]     cur_sid_q, cur_sid_d;
    logic [SEQ_NUM_W-1:0] cur_seq_q, cur_seq_d;
    logic [SEQ_NUM_W-1:0] rem_q, rem_d;
    logic                 ovf_q, ovf_d;

    miss_range_t          head, tail, push_data;
    logic                 full, empty, last_entry;
    logic                 pop, push_req, fifo_push, merge;
    logic [SEQ_NUM_W-1:0] merge_cnt;
    logic [SEQ_NUM_W-1:0] chunk;
    logic                 hs, last_chunk;

    assign push_data = '{sid: miss_sid_i, start: miss_start_i, cnt: miss_cnt_i};
    assign push_req  = miss_v_i && (miss_cnt_i != '0);

`ifdef MISS_REQ_MERGE_EN
    logic [SEQ_NUM_W:0] sum_ext;
    assign sum_ext   = add_carry(tail.cnt, miss_cnt_i);
    assign merge_cnt = sum_ext[SEQ_NUM_W-1:0];
    // Skip merging into an entry leaving this cycle, or when the count would wrap.
    assign merge = push_req && !empty && (tail.sid == miss_sid_i)
                && (miss_start_i == tail.start + tail.cnt)
                && !(pop && last_entry) && !sum_ext[SEQ_NUM_W];
`else
    logic unused_tail;
    assign unused_tail = ^{tail, last_entry};
    assign merge_cnt   = '0;
    assign merge       = 1'b0;
`endif

    assign fifo_push = push_req && !merge;

    miss_req_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .nreset    (nreset),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .last_entry(last_entry),
        .tail      (tail),
        .tail_upd  (merge),
        .tail_cnt  (merge_cnt)
    );

    // Chunk splitter: current request size and handshake decode.
    always_comb begin
        chunk      = (rem_q > MAX_EXT) ? MAX_EXT : rem_q;
        hs         = (state_q == StSend) && req_ready_i;
        last_chunk = hs && (rem_q <= MAX_EXT);
    end

    // Next-state: load from FIFO head when idle or when a range finishes (no bubble).
    always_comb begin
        state_d   = state_q;
        cur_sid_d = cur_sid_q;
        cur_seq_d = cur_seq_q;
        rem_d     = rem_q;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop       = 1'b1;
                    cur_sid_d = head.sid;
                    cur_seq_d = head.start;
                    rem_d     = head.cnt;
                    state_d   = StSend;
                end
            end
            StSend: begin
                if (hs) begin
                    cur_seq_d = cur_seq_q + chunk;
                    rem_d     = rem_q - chunk;
                    if (last_chunk) begin
                        if (!empty) begin
                            pop       = 1'b1;
                            cur_sid_d = head.sid;
                            cur_seq_d = head.start;
                            rem_d     = head.cnt;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sticky overflow: a range neither merged nor stored because the FIFO stayed full.
    always_comb begin
        ovf_d = ovf_q || (fifo_push && full && !pop);
    end

    // State and request registers.
    always_ff @(posedge clk) begin
        if (nreset) begin
            state_q   <= StIdle;
            cur_sid_q <= '0;
            cur_seq_q <= '0;
            rem_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_sid_q <= cur_sid_d;
            cur_seq_q <= cur_seq_d;
            rem_q     <= rem_d;
            ovf_q     <= ovf_d;
        end
    end

    assign req_v_o       = (state_q == StSend);
    assign req_sid_o     = cur_sid_q;
    assign req_seq_num_o = cur_seq_q;
    assign req_msg_cnt_o = chunk[ML_W-1:0];
    assign busy_o        = !empty || (state_q == StSend);
    assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_miss_req_gen.sv
// Bench for miss_req_gen: directed steps plus random bursts against a
// range-splitting reference model. Honors MISS_REQ_MERGE_EN for the merge case.
module tb_miss_req_gen;

    localparam int unsigned MAXC = 16'hFFFF;

    typedef struct packed {
        logic [79:0] sid;
        logic [63:0] seq;
        logic [15:0] cnt;
    } req_t;

    logic        clk = 1'b0;
    logic        nreset;
    logic        miss_v_i;
    logic [79:0] miss_sid_i;
    logic [63:0] miss_start_i;
    logic [63:0] miss_cnt_i;
    logic        req_v_o;
    logic        req_ready_i;
    logic [79:0] req_sid_o;
    logic [63:0] req_seq_num_o;
    logic [15:0] req_msg_cnt_o;
    logic        busy_o;
    logic        ovf_o;

    req_t exp_q[$];
    req_t got_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    miss_req_gen #(
        .SEQ_NUM_W  (64),
        .SID_W      (80),
        .ML_W       (16),
        .FIFO_DEPTH (4),
        .MAX_REQ_CNT(MAXC)
    ) dut (
        .clk          (clk),
        .nreset       (nreset),
        .miss_v_i     (miss_v_i),
        .miss_sid_i   (miss_sid_i),
        .miss_start_i (miss_start_i),
        .miss_cnt_i   (miss_cnt_i),
        .req_v_o      (req_v_o),
        .req_ready_i  (req_ready_i),
        .req_sid_o    (req_sid_o),
        .req_seq_num_o(req_seq_num_o),
        .req_msg_cnt_o(req_msg_cnt_o),
        .busy_o       (busy_o),
        .ovf_o        (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: capture handshakes and check fields hold while stalled.
    req_t cur_req, prev_req;
    logic prev_v = 1'b0, prev_rdy = 1'b0, prev_rst = 1'b1;
    always @(negedge clk) begin
        cur_req = '{sid: req_sid_o, seq: req_seq_num_o, cnt: req_msg_cnt_o};
        if (prev_v && !prev_rdy && !prev_rst) begin
            check("hold_valid", 160'(req_v_o), 160'(1));
            check("hold_fields", 160'(cur_req), 160'(prev_req));
        end
        if (req_v_o && req_ready_i && !nreset) got_q.push_back(cur_req);
        prev_v   = req_v_o;
        prev_rdy = req_ready_i;
        prev_rst = nreset;
        prev_req = cur_req;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nreset   = 1'b1;
        miss_v_i = 1'b0;
        tick();
        tick();
        nreset = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic push(input logic [79:0] sid, input logic [63:0] st, input logic [63:0] cnt);
        miss_v_i     = 1'b1;
        miss_sid_i   = sid;
        miss_start_i = st;
        miss_cnt_i   = cnt;
        tick();
        miss_v_i = 1'b0;
    endtask

    // Reference model: a range becomes consecutive requests of at most MAXC messages.
    function automatic void expand(input logic [79:0] sid, input logic [63:0] st,
                                   input logic [63:0] cnt);
        logic [63:0] s = st;
        logic [63:0] r = cnt;
        logic [63:0] c;
        while (r != 0) begin
            c = (r > 64'(MAXC)) ? 64'(MAXC) : r;
            exp_q.push_back('{sid: sid, seq: s, cnt: c[15:0]});
            s = s + c;
            r = r - c;
        end
    endfunction

    task automatic drain(input int bound, input bit rnd);
        int n = 0;
        while (busy_o && n < bound) begin
            req_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        check("drain_idle", 160'(busy_o), 160'(0));
        req_ready_i = 1'b0;
    endtask

    task automatic check_sb(input string tag);
        int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        check({tag, "_count"}, 160'(got_q.size()), 160'(exp_q.size()));
        for (int i = 0; i < n; i++) check(tag, 160'(got_q[i]), 160'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [63:0] tseq [3];
        logic [15:0] tcnt [3];
        logic [79:0] rsid;
        logic [63:0] rcnt, rst_seq;
        int          nb, sel;

        nreset       = 1'b1;
        miss_v_i     = 1'b0;
        miss_sid_i   = '0;
        miss_start_i = '0;
        miss_cnt_i   = '0;
        req_ready_i  = 1'b0;
        tick();
        tick();
        tick();
        nreset = 1'b0;
        tick();

        // Reset state
        check("rst_req_v", 160'(req_v_o), 160'(0));
        check("rst_busy", 160'(busy_o), 160'(0));
        check("rst_ovf", 160'(ovf_o), 160'(0));
        check("rst_fields", 160'({req_sid_o, req_seq_num_o, req_msg_cnt_o}), 160'(0));

        // Single range and its latency
        req_ready_i = 1'b1;
        push(80'd5, 64'd100, 64'd10);
        expand(80'd5, 64'd100, 64'd10);
        check("t1_v_edge1", 160'(req_v_o), 160'(0));
        check("t1_busy", 160'(busy_o), 160'(1));
        tick();
        check("t1_v_edge2", 160'(req_v_o), 160'(1));
        check("t1_fields", 160'({req_sid_o, req_seq_num_o, req_msg_cnt_o}),
              160'({80'd5, 64'd100, 16'd10}));
        tick();
        check("t1_v_done", 160'(req_v_o), 160'(0));
        check("t1_busy_done", 160'(busy_o), 160'(0));
        check_sb("t1_sb");

        // Split into three back-to-back requests
        tseq[0] = 64'h1000;
        tseq[1] = 64'h1000 + 64'hFFFF;
        tseq[2] = 64'h1000 + 64'h1FFFE;
        tcnt[0] = 16'hFFFF;
        tcnt[1] = 16'hFFFF;
        tcnt[2] = 16'd7;
        push(80'h2222, 64'h1000, 64'h2_0005);
        expand(80'h2222, 64'h1000, 64'h2_0005);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_v", 160'(req_v_o), 160'(1));
            check("t2_fields", 160'({req_sid_o, req_seq_num_o, req_msg_cnt_o}),
                  160'({80'h2222, tseq[i], tcnt[i]}));
        end
        tick();
        check("t2_v_done", 160'(req_v_o), 160'(0));
        check_sb("t2_sb");

        // Backpressure: fields hold, exactly one request accepted
        req_ready_i = 1'b0;
        push(80'd3, 64'd500, 64'd20);
        expand(80'd3, 64'd500, 64'd20);
        tick();
        check("t3_v", 160'(req_v_o), 160'(1));
        for (int i = 0; i < 5; i++) tick();
        check("t3_none_yet", 160'(got_q.size()), 160'(0));
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        check("t3_v_done", 160'(req_v_o), 160'(0));
        tick();
        check_sb("t3_sb");

        // Overflow: one in flight, four queued, sixth dropped
        for (int i = 0; i < 6; i++) begin
            push(80'(40 + i), 64'(1000 * i), 64'(i + 1));
            if (i < 5) expand(80'(40 + i), 64'(1000 * i), 64'(i + 1));
            if (i == 4) check("t4_no_ovf", 160'(ovf_o), 160'(0));
        end
        check("t4_ovf", 160'(ovf_o), 160'(1));
        drain(200, 1'b0);
        check_sb("t4_sb");
        check("t4_ovf_sticky", 160'(ovf_o), 160'(1));
        do_reset();
        check("t4_ovf_cleared", 160'(ovf_o), 160'(0));

        // Push into a full FIFO in the same cycle a pop frees a slot
        for (int i = 0; i < 5; i++) begin
            push(80'(60 + i), 64'(77 * i), 64'd1);
            expand(80'(60 + i), 64'(77 * i), 64'd1);
        end
        req_ready_i = 1'b1;
        push(80'd65, 64'd999, 64'd2);
        expand(80'd65, 64'd999, 64'd2);
        check("t4b_no_ovf", 160'(ovf_o), 160'(0));
        drain(200, 1'b0);
        check_sb("t4b_sb");
        check("t4b_no_ovf_end", 160'(ovf_o), 160'(0));

        // Sequence-number wrap
        push(80'd8, 64'hFFFF_FFFF_FFFF_FFFD, 64'h1_0002);
        expand(80'd8, 64'hFFFF_FFFF_FFFF_FFFD, 64'h1_0002);
        drain(100, 1'b0);
        rst_seq = (got_q.size() > 1) ? got_q[1].seq : 64'h0;
        check("t5_wrap_seq", 160'(rst_seq), 160'(64'hFFFC));
        check_sb("t5_sb");

        // Contiguous ranges behind a busy FSM
        req_ready_i = 1'b0;
        push(80'd9, 64'd1000, 64'd1);
        push(80'd7, 64'd50, 64'd5);
        push(80'd7, 64'd55, 64'd3);
        expand(80'd9, 64'd1000, 64'd1);
`ifdef MISS_REQ_MERGE_EN
        expand(80'd7, 64'd50, 64'd8);
`else
        expand(80'd7, 64'd50, 64'd5);
        expand(80'd7, 64'd55, 64'd3);
`endif
        drain(100, 1'b0);
        check_sb("t6_sb");

        // Zero-count push is ignored
        push(80'd11, 64'd5, 64'd0);
        check("t7_zero_busy", 160'(busy_o), 160'(0));

        // Reset mid-request abandons the range
        push(80'd1, 64'd0, 64'h3_0000);
        tick();
        check("t8_v", 160'(req_v_o), 160'(1));
        do_reset();
        check("t8_v_rst", 160'(req_v_o), 160'(0));
        check("t8_busy_rst", 160'(busy_o), 160'(0));
        check("t8_cnt_rst", 160'(req_msg_cnt_o), 160'(0));
        req_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        req_ready_i = 1'b0;
        check_sb("t8_sb");

        // Random bursts with random backpressure
        for (int it = 0; it < 25; it++) begin
            nb = $urandom_range(1, 4);
            for (int j = 0; j < nb; j++) begin
                rsid      = {16'($urandom), $urandom, $urandom};
                rsid[7:0] = 8'(j);
                sel       = $urandom_range(0, 5);
                if (sel == 0) rcnt = 64'd0;
                else if (sel == 1) rcnt = 64'h1_0000 + 64'($urandom_range(0, 32'h2_0000));
                else rcnt = 64'($urandom_range(1, 50));
                rst_seq     = {$urandom, $urandom};
                req_ready_i = 1'($urandom_range(0, 1));
                push(rsid, rst_seq, rcnt);
                expand(rsid, rst_seq, rcnt);
            end
            drain(3000, 1'b1);
            check_sb("rand_sb");
        end
        check("rand_no_ovf", 160'(ovf_o), 160'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
